// File: rtl/pipe_addsub_acc_pkg.sv
// Shared types and helpers for the pipe_addsub_acc block: op-code encoding and
// the per-bit saturation helper used by the ALU when saturation is enabled.
package pipe_addsub_acc_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  // Works bit by bit so it is width-agnostic: on overflow the MSB takes the true
  // sign and every lower bit its complement (0x7FF..F or 0x800..0).
  function automatic logic sat_w(input logic bit_in, input logic ovf,
                                 input logic neg, input logic is_msb);
    if (!ovf) return bit_in;
    return is_msb ? neg : !neg;
  endfunction

endpackage

// File: rtl/pipe_addsub_acc_if.sv
// Operand/result handshake bundle for pipe_addsub_acc. The producer and consumer
// side (testbench) uses master; the unit uses slave.
interface pipe_addsub_acc_if
  import pipe_addsub_acc_pkg::*;
#(
  parameter int W = 16
) ();
  logic         in_valid;
  logic         in_ready;
  op_e          op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         carry;
  logic         ovf;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, carry, ovf
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, carry, ovf
  );
endinterface

// File: rtl/pipe_addsub_acc_alu.sv
// Combinational ADD/SUB/ACC/LOAD datapath with carry/borrow and signed overflow.
// Define PIPE_ADDSUB_ACC_SAT_EN to clamp overflowing results instead of wrapping.
module pipe_addsub_acc_alu
  import pipe_addsub_acc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] acc,
  input  op_e          op,
  output logic [W-1:0] y,
  output logic         carry,
  output logic         ovf
);
  logic [W:0]   sum_add;
  logic [W:0]   sum_sub;
  logic [W:0]   sum_acc;
  logic [W-1:0] raw;

  // Bit W of the zero-extended difference is the unsigned borrow (a < b).
  assign sum_add = {1'b0, a} + {1'b0, b};
  assign sum_sub = {1'b0, a} - {1'b0, b};
  assign sum_acc = {1'b0, acc} + {1'b0, a};

  always_comb begin
    raw   = a;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        raw   = sum_add[W-1:0];
        carry = sum_add[W];
        ovf   = (a[W-1] == b[W-1]) && (sum_add[W-1] != a[W-1]);
      end
      OP_SUB: begin
        raw   = sum_sub[W-1:0];
        carry = sum_sub[W];
        ovf   = (a[W-1] != b[W-1]) && (sum_sub[W-1] != a[W-1]);
      end
      OP_ACC: begin
        raw   = sum_acc[W-1:0];
        carry = sum_acc[W];
        ovf   = (acc[W-1] == a[W-1]) && (sum_acc[W-1] != acc[W-1]);
      end
      default: ;
    endcase
  end

`ifdef PIPE_ADDSUB_ACC_SAT_EN
  logic sat_neg;

  // On overflow the true sign is that of the first operand (acc for ACC).
  assign sat_neg = (op == OP_ACC) ? acc[W-1] : a[W-1];

  always_comb begin
    y = raw;
    for (int i = 0; i < W; i++) begin
      y[i] = sat_w(raw[i], ovf, sat_neg, i == W - 1);
    end
  end
`else
  assign y = raw;
`endif

endmodule

// File: rtl/pipe_addsub_acc.sv
// pipe_addsub_acc: pipelined add/sub/accumulate with valid/ready on both sides.
// Saturating results are selected at build time with PIPE_ADDSUB_ACC_SAT_EN.
module pipe_addsub_acc
  import pipe_addsub_acc_pkg::*;
#(
  parameter int W      = 16,
  parameter int STAGES = 3
) (
  input logic              clk,
  input logic              rst,
  pipe_addsub_acc_if.slave bus
);
  logic         stall;

  logic         vld_p1;
  logic [W-1:0] a_p1;
  logic [W-1:0] b_p1;
  op_e          op_p1;

  logic [W-1:0] acc;
  logic [W-1:0] alu_y;
  logic         alu_carry;
  logic         alu_ovf;

  logic         vld_pn   [2:STAGES];
  logic [W-1:0] y_pn     [2:STAGES];
  logic         carry_pn [2:STAGES];
  logic         ovf_pn   [2:STAGES];

  // A held result freezes the whole pipe, so nothing can be overwritten or lost.
  assign stall        = vld_pn[STAGES] && !bus.out_ready;
  assign bus.in_ready = !rst && !stall;

  // Stage 1: operand capture
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= bus.in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      a_p1  <= bus.a;
      b_p1  <= bus.b;
      op_p1 <= bus.op;
    end
  end

  pipe_addsub_acc_alu #(.W(W)) u_alu (
    .a     (a_p1),
    .b     (b_p1),
    .acc   (acc),
    .op    (op_p1),
    .y     (alu_y),
    .carry (alu_carry),
    .ovf   (alu_ovf)
  );

  // Stage 2: result/flags registered, acc updated; stages 3..STAGES delay only
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pn[s]   <= 1'b0;
        y_pn[s]     <= '0;
        carry_pn[s] <= 1'b0;
        ovf_pn[s]   <= 1'b0;
      end
    end else if (!stall) begin
      vld_pn[2]   <= vld_p1;
      y_pn[2]     <= alu_y;
      carry_pn[2] <= alu_carry;
      ovf_pn[2]   <= alu_ovf;
      for (int s = 3; s <= STAGES; s++) begin
        vld_pn[s]   <= vld_pn[s-1];
        y_pn[s]     <= y_pn[s-1];
        carry_pn[s] <= carry_pn[s-1];
        ovf_pn[s]   <= ovf_pn[s-1];
      end
      if (vld_p1 && (op_p1 == OP_ACC || op_p1 == OP_LOAD)) begin
        acc <= alu_y;
      end
    end
  end

  assign bus.out_valid = vld_pn[STAGES];
  assign bus.y         = y_pn[STAGES];
  assign bus.carry     = carry_pn[STAGES];
  assign bus.ovf       = ovf_pn[STAGES];

endmodule
